// File: rtl/pipelined_adder.sv
// Pipelined carry-propagate adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready handshake with global stall.
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;
    // Intermediate register count; kept at least 1 so STAGES=1 still elaborates.
    localparam int PIPE  = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic [WIDTH-1:0] a_q   [PIPE];
    logic [WIDTH-1:0] a_d   [PIPE];
    logic [WIDTH-1:0] b_q   [PIPE];
    logic [WIDTH-1:0] b_d   [PIPE];
    logic [WIDTH-1:0] sum_q [PIPE];
    logic [WIDTH-1:0] sum_d [PIPE];
    logic [PIPE-1:0]  c_q, c_d;
    logic [PIPE-1:0]  vld_q, vld_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic             stall_s;
    logic [WIDTH-1:0] cur_a, cur_b, cur_sum;
    logic             cur_c, cur_v;
    logic [CHUNK:0]   chunk_s;

    // Per-stage chunk add and next-state selection; a stall freezes every stage.
    always_comb begin
        stall_s     = out_valid_q & ~out_ready;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        c_d         = c_q;
        vld_d       = vld_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        cur_a       = {WIDTH{1'b0}};
        cur_b       = {WIDTH{1'b0}};
        cur_sum     = {WIDTH{1'b0}};
        cur_c       = 1'b0;
        cur_v       = 1'b0;
        chunk_s     = {(CHUNK+1){1'b0}};
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                cur_a   = op1;
                cur_b   = sub ? ~op2 : op2;
                cur_c   = sub | carry_in;
                cur_sum = {WIDTH{1'b0}};
                cur_v   = in_valid;
            end else begin
                cur_a   = a_q[(s > 0) ? s - 1 : 0];
                cur_b   = b_q[(s > 0) ? s - 1 : 0];
                cur_sum = sum_q[(s > 0) ? s - 1 : 0];
                cur_c   = c_q[(s > 0) ? s - 1 : 0];
                cur_v   = vld_q[(s > 0) ? s - 1 : 0];
            end
            chunk_s = {1'b0, cur_a[s*CHUNK +: CHUNK]} + {1'b0, cur_b[s*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, cur_c};
            cur_sum[s*CHUNK +: CHUNK] = chunk_s[CHUNK-1:0];
            if (s < STAGES - 1) begin
                if (!stall_s) begin
                    a_d[(s < PIPE) ? s : PIPE - 1]   = cur_a;
                    b_d[(s < PIPE) ? s : PIPE - 1]   = cur_b;
                    sum_d[(s < PIPE) ? s : PIPE - 1] = cur_sum;
                    c_d[(s < PIPE) ? s : PIPE - 1]   = chunk_s[CHUNK];
                    vld_d[(s < PIPE) ? s : PIPE - 1] = cur_v;
                end else begin
                    vld_d[(s < PIPE) ? s : PIPE - 1] = vld_q[(s < PIPE) ? s : PIPE - 1];
                end
            end else begin
                if (!stall_s && cur_v) begin
                    result_d    = cur_sum;
                    carry_out_d = chunk_s[CHUNK];
                    // Carry into the MSB is recovered from the MSB sum bit.
                    overflow_d  = chunk_s[CHUNK] ^ cur_sum[WIDTH-1] ^ cur_a[WIDTH-1] ^ cur_b[WIDTH-1];
                    zero_d      = ~|cur_sum;
                end else begin
                    result_d    = result_q;
                end
                out_valid_d = stall_s ? out_valid_q : cur_v;
            end
        end
    end

    // Pipeline and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                a_q[i]   <= {WIDTH{1'b0}};
                b_q[i]   <= {WIDTH{1'b0}};
                sum_q[i] <= {WIDTH{1'b0}};
            end
            c_q         <= {PIPE{1'b0}};
            vld_q       <= {PIPE{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            c_q         <= c_d;
            vld_q       <= vld_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 64-bit/4-stage with scoreboard, plus 8-bit/1-stage.
module tb_pipelined_adder;
    localparam int W = 64;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, carry_in, sub, out_valid, out_ready;
    logic         carry_out, overflow, zero;
    logic [W-1:0] op1, op2, result;

    logic         b_in_valid, b_in_ready, b_carry_in, b_sub, b_out_valid, b_out_ready;
    logic         b_carry_out, b_overflow, b_zero;
    logic [7:0]   b_op1, b_op2, b_result;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op1(b_op1), .op2(b_op2), .carry_in(b_carry_in), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
        .carry_out(b_carry_out), .overflow(b_overflow), .zero(b_zero)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         co, ov, z;
        int           cyc;
        bit           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         ci, sb;
        logic [W-1:0] res;
        logic         co, ov, z;
    } vec_t;

    typedef struct {
        logic [7:0] a, b;
        logic       ci, sb;
        logic [7:0] res;
        logic       co, ov, z;
    } vec8_t;

    exp_t sbq[$];
    exp_t cur_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   cyc   = 0;
    bit   lat_en = 1'b1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t       e;
        logic [W:0] full;
        if (sb) begin
            e.res = a - b;
            e.co  = (a >= b);
            e.ov  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end else begin
            full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            e.res = full[W-1:0];
            e.co  = full[W];
            e.ov  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        e.z   = (e.res == {W{1'b0}});
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard: pop/compare delivered beats, push expectations for accepted beats.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (out_valid && out_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got result=%h with nothing pending", result);
            end else begin
                e = sbq.pop_front();
                n_pop++;
                if ({result, carry_out, overflow, zero} !== {e.res, e.co, e.ov, e.z}) begin
                    n_err++;
                    $display("FAIL beat: got res=%h co=%b ov=%b z=%b required res=%h co=%b ov=%b z=%b",
                             result, carry_out, overflow, zero, e.res, e.co, e.ov, e.z);
                end
                if (e.lat) begin
                    n_cmp++;
                    if (cyc - e.cyc != S) begin
                        n_err++;
                        $display("FAIL latency: got %0d required %0d", cyc - e.cyc, S);
                    end
                end
            end
        end
        if (in_valid && in_ready && !rst) begin
            e     = cur_exp;
            e.cyc = cyc;
            e.lat = lat_en;
            sbq.push_back(e);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input exp_t e);
        int t;
        op1 = a; op2 = b; carry_in = ci; sub = sb; cur_exp = e;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
        end
    endtask

    vec_t  vt[8];
    vec8_t v8[3];

    initial begin
        exp_t e;
        int   pops0, t;
        logic [W-1:0] a, b, hold;
        logic ci, sb;

        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        vt[1] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[2] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
        vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        vt[6] = '{64'h1234, 64'h1, 1'b1, 1'b1, 64'h1233, 1'b1, 1'b0, 1'b0};
        vt[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};

        v8[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        v8[1] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        v8[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op1 = '0; op2 = '0; carry_in = 1'b0; sub = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_op1 = '0; b_op2 = '0; b_carry_in = 1'b0; b_sub = 1'b0;
        cur_exp = model('0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_outputs", {result[W-1:3] | result[2:0], carry_out, overflow, zero}, 64'h0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
        chk("rst8_out_valid", {63'b0, b_out_valid}, 64'h0);
        @(posedge clk); #1;

        // Directed vectors, streamed back-to-back.
        for (int i = 0; i < 8; i++) begin
            e.res = vt[i].res; e.co = vt[i].co; e.ov = vt[i].ov; e.z = vt[i].z;
            send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, e);
        end
        drain();

        // Random back-to-back stream.
        for (int i = 0; i < 20; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            ci = 1'($urandom_range(1, 0));
            sb = (i >= 10) ? 1'($urandom_range(1, 0)) : 1'b0;
            send(a, b, ci, sb, model(a, b, ci, sb));
        end
        drain();

        // Backpressure: 5-cycle stall on the first result.
        lat_en = 1'b0;
        out_ready = 1'b0;
        pops0 = n_pop;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom};
                    send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
                end
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 50) begin t++; @(negedge clk); end
                hold = result;
                for (int k = 0; k < 5; k++) begin
                    chk("stall_in_ready", {63'b0, in_ready}, 64'h0);
                    chk("stall_out_valid", {63'b0, out_valid}, 64'h1);
                    chk("stall_result_hold", result, hold);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_beats_delivered", 64'(n_pop - pops0), 64'd6);
        lat_en = 1'b1;

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            a = 64'(i + 1); b = 64'h10;
            send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
        end
        rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("midrst_result", result, 64'h0);
        chk("midrst_flags", {61'b0, carry_out, overflow, zero}, 64'h0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'h1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_pending", 64'(sbq.size()), 64'h0);
        send(64'hDEAD, 64'hBEEF, 1'b1, 1'b0, model(64'hDEAD, 64'hBEEF, 1'b1, 1'b0));
        drain();
        chk("post_rst_beat_done", 64'(sbq.size()), 64'h0);

        // Single-stage 8-bit instance: one-cycle latency.
        for (int i = 0; i < 3; i++) begin
            b_op1 = v8[i].a; b_op2 = v8[i].b; b_carry_in = v8[i].ci; b_sub = v8[i].sb;
            b_in_valid = 1'b1;
            @(negedge clk);
            chk("w8_in_ready", {63'b0, b_in_ready}, 64'h1);
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            @(negedge clk);
            chk("w8_out_valid", {63'b0, b_out_valid}, 64'h1);
            chk("w8_result", {56'b0, b_result}, {56'b0, v8[i].res});
            chk("w8_flags", {61'b0, b_carry_out, b_overflow, b_zero},
                {61'b0, v8[i].co, v8[i].ov, v8[i].z});
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
